// File: rtl/por_trip_cal.sv
`default_nettype none
// ============================================================================
// Module      : por_trip_cal
// Description : Trip-point calibration sequencer for the POR analog front end.
//               On a start request it sweeps the 3-bit trip-select code driven
//               to the rstring mux through all eight settings. At each code it
//               waits for the comparator to settle, then takes a window of
//               synchronized pwup_filt samples. A code passes only if every
//               sample in its window is 1. When the sweep ends, the highest
//               passing code is reported and driven back to the analog block,
//               provided the passing codes form a contiguous run starting at
//               code 0.
//
// Ports       :
//   osc_ck     in   1  main clock (RC oscillator)
//   resetb     in   1  asynchronous active-low reset
//   start      in   1  calibration request, honoured only while idle
//   abort      in   1  cancel the sweep, effective in any state
//   pwup_filt  in   1  comparator output (asynchronous, synchronized here)
//   otrip_cal  out  3  trip-select code to the analog mux
//   cal_active out  1  high while a code is settling or being sampled
//   cal_done   out  1  one-cycle pulse when a sweep completes
//   cal_valid  out  1  last completed sweep passed (cleared by start)
//   cal_fail   out  1  last completed sweep failed (cleared by start)
//   cal_code   out  3  result code (highest passing code or DEFAULT_CODE)
//   hit_map    out  8  bit c = pass/fail of code c from the last sweep
//
// Revision    : 1.0 - initial release
// ============================================================================
module por_trip_cal #(
    parameter int         SETTLE_CYC   = 64,    // settle cycles per code, >= 4
    parameter int         NSAMP        = 8,     // samples per code, all must be 1
    parameter logic [2:0] DEFAULT_CODE = 3'd4   // code after reset / failed sweep
) (
    input  logic       osc_ck,
    input  logic       resetb,
    input  logic       start,
    input  logic       abort,
    input  logic       pwup_filt,
    output logic [2:0] otrip_cal,
    output logic       cal_active,
    output logic       cal_done,
    output logic       cal_valid,
    output logic       cal_fail,
    output logic [2:0] cal_code,
    output logic [7:0] hit_map
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Counter widths are guarded so a degenerate count of 1 still yields a
    // legal one-bit counter.
    localparam int C_SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int C_SAMP_W   = (NSAMP > 1)      ? $clog2(NSAMP)      : 1;

    localparam logic [C_SETTLE_W-1:0] C_SETTLE_LAST = C_SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [C_SAMP_W-1:0]   C_SAMP_LAST   = C_SAMP_W'(NSAMP - 1);

    localparam logic [2:0] C_LAST_CODE = 3'd7;

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_SETTLE = 2'd1;
    localparam logic [1:0] C_ST_SAMPLE = 2'd2;
    localparam logic [1:0] C_ST_DONE   = 2'd3;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [2:0]            r_code;        // code currently under test
    logic [C_SETTLE_W-1:0] r_settle_cnt;
    logic [C_SAMP_W-1:0]   r_samp_cnt;
    logic                  r_pass;        // running AND of samples for r_code
    logic [1:0]            r_sync;        // pwup_filt synchronizer, [1] is safe
    logic [7:0]            r_hit_map;
    logic [2:0]            r_cal_code;
    logic                  r_cal_valid;
    logic                  r_cal_fail;

    // ------------------------------------------------------------------------
    // Result decode
    // ------------------------------------------------------------------------
    // A sweep passes when the set bits of hit_map form a run starting at
    // bit 0 with no set bit above the first clear bit. The reported code is
    // the index of the highest set bit, which for a valid run is its length-1.
    logic       w_gap_seen;
    logic       w_non_therm;
    logic       w_sweep_ok;
    logic [2:0] w_top_code;

    always_comb begin
        w_gap_seen  = 1'b0;
        w_non_therm = 1'b0;
        w_top_code  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_hit_map[i]) begin
                w_top_code = 3'(i);
                if (w_gap_seen) begin
                    w_non_therm = 1'b1;
                end
            end else begin
                w_gap_seen = 1'b1;
            end
        end
        w_sweep_ok = r_hit_map[0] && !w_non_therm;
    end

    // ------------------------------------------------------------------------
    // Comparator synchronizer
    // ------------------------------------------------------------------------
    always_ff @(posedge osc_ck or negedge resetb) begin
        if (!resetb) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], pwup_filt};
        end
    end

    // ------------------------------------------------------------------------
    // Sweep sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge osc_ck or negedge resetb) begin
        if (!resetb) begin
            r_state      <= C_ST_IDLE;
            r_code       <= 3'd0;
            r_settle_cnt <= '0;
            r_samp_cnt   <= '0;
            r_pass       <= 1'b0;
            r_hit_map    <= 8'h00;
            r_cal_code   <= DEFAULT_CODE;
            r_cal_valid  <= 1'b0;
            r_cal_fail   <= 1'b0;
        end else if (abort) begin
            // Abort wins everywhere, including over a coincident start in
            // IDLE. Results and any partially filled hit_map are left as-is.
            r_state <= C_ST_IDLE;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (start) begin
                        r_hit_map    <= 8'h00;
                        r_cal_valid  <= 1'b0;
                        r_cal_fail   <= 1'b0;
                        r_code       <= 3'd0;
                        r_settle_cnt <= '0;
                        r_state      <= C_ST_SETTLE;
                    end
                end

                C_ST_SETTLE: begin
                    if (r_settle_cnt == C_SETTLE_LAST) begin
                        r_samp_cnt <= '0;
                        r_pass     <= 1'b1;
                        r_state    <= C_ST_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end

                C_ST_SAMPLE: begin
                    if (r_samp_cnt == C_SAMP_LAST) begin
                        // Fold the final sample in directly so the verdict is
                        // written on the same edge the window closes.
                        r_hit_map[r_code] <= r_pass & r_sync[1];
                        if (r_code == C_LAST_CODE) begin
                            r_state <= C_ST_DONE;
                        end else begin
                            r_code       <= r_code + 3'd1;
                            r_settle_cnt <= '0;
                            r_state      <= C_ST_SETTLE;
                        end
                    end else begin
                        r_pass     <= r_pass & r_sync[1];
                        r_samp_cnt <= r_samp_cnt + 1'b1;
                    end
                end

                C_ST_DONE: begin
                    if (w_sweep_ok) begin
                        r_cal_code  <= w_top_code;
                        r_cal_valid <= 1'b1;
                    end else begin
                        r_cal_code <= DEFAULT_CODE;
                        r_cal_fail <= 1'b1;
                    end
                    r_state <= C_ST_IDLE;
                end

                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // While idle the analog mux sees the calibrated result; during a sweep it
    // sees the code under test. Selecting on the registered state means an
    // abort hands the mux back to cal_code on the very next edge.
    assign otrip_cal  = (r_state == C_ST_IDLE) ? r_cal_code : r_code;
    assign cal_active = (r_state == C_ST_SETTLE) || (r_state == C_ST_SAMPLE);
    // An abort landing in the DONE cycle suppresses the completion pulse,
    // matching the results that are also left unchanged in that case.
    assign cal_done   = (r_state == C_ST_DONE) && !abort;
    assign cal_valid  = r_cal_valid;
    assign cal_fail   = r_cal_fail;
    assign cal_code   = r_cal_code;
    assign hit_map    = r_hit_map;

endmodule
`default_nettype wire

// File: tb/tb_por_trip_cal.sv
`default_nettype none
// ============================================================================
// Module      : tb_por_trip_cal
// Description : Self-checking bench for por_trip_cal with default parameters.
//               The comparator is emulated from a per-code pass map indexed by
//               the code the DUT drives; expected results come from a
//               behavioural model of the sweep outcome.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_por_trip_cal;

    localparam int C_CODE_CYC = 64 + 8;          // settle + sample per code
    localparam int C_DONE_N   = 8 * C_CODE_CYC;  // edges from start edge to DONE

    logic       osc_ck;
    logic       resetb;
    logic       start;
    logic       abort;
    logic       pwup_filt;
    logic [2:0] otrip_cal;
    logic       cal_active;
    logic       cal_done;
    logic       cal_valid;
    logic       cal_fail;
    logic [2:0] cal_code;
    logic [7:0] hit_map;

    por_trip_cal dut (
        .osc_ck     (osc_ck),
        .resetb     (resetb),
        .start      (start),
        .abort      (abort),
        .pwup_filt  (pwup_filt),
        .otrip_cal  (otrip_cal),
        .cal_active (cal_active),
        .cal_done   (cal_done),
        .cal_valid  (cal_valid),
        .cal_fail   (cal_fail),
        .cal_code   (cal_code),
        .hit_map    (hit_map)
    );

    initial osc_ck = 1'b0;
    always #5 osc_ck = ~osc_ck;

    // Comparator emulation: the analog block passes code c when pass_map[c].
    logic [7:0] pass_map;
    logic       glitch;
    initial begin
        pass_map  = 8'h00;
        glitch    = 1'b0;
        pwup_filt = 1'b0;
    end
    always @(negedge osc_ck) pwup_filt = pass_map[otrip_cal] | glitch;

    int checks;
    int errors;

    // Model state of the DUT's result outputs
    logic [2:0] m_code;
    logic       m_valid;
    logic       m_fail;
    logic [7:0] m_hit;

    task automatic tick();
        @(posedge osc_ck);
        #1;
    endtask

    // Outcome of a sweep: longest run of passing codes from 0; the sweep is
    // good only if nothing passes above that run and the run is non-empty.
    function automatic void model_result(input logic [7:0] m, output logic ok,
                                         output logic [2:0] code);
        int n;
        n = 0;
        while (n < 8 && m[n]) n++;
        ok = (n > 0);
        for (int i = n; i < 8; i++) if (m[i]) ok = 1'b0;
        code = ok ? 3'(n - 1) : 3'd4;
    endfunction

    task automatic start_sweep();
        start = 1'b1;
        tick();            // this edge samples start
        start = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        resetb = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        repeat (3) tick();
        resetb = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (otrip_cal !== 3'd4 || cal_active !== 1'b0 || cal_done !== 1'b0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_idle_trace: %0d bad cycles, required 0", bad);
        end
        checks++;
        if (cal_valid !== 1'b0 || cal_fail !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b fail=%b, required 0 0", cal_valid, cal_fail);
        end
        checks++;
        if (hit_map !== 8'h00 || cal_code !== 3'd4) begin
            errors++;
            $display("FAIL reset_results: hit_map=%h code=%0d, required 00 4", hit_map, cal_code);
        end
        m_code = 3'd4; m_valid = 1'b0; m_fail = 1'b0; m_hit = 8'h00;
    endtask

    // Full sweep with an optional one-cycle glitch in code 0's sample window
    // and an optional start pulse mid-sweep that must be ignored.
    task automatic test_sweep(input logic [7:0] map, input bit glitch_c0,
                              input bit start_noise, input string name);
        logic       exp_ok;
        logic [2:0] exp_code;
        int         n;
        int         done_at;
        int         bad;
        model_result(map, exp_ok, exp_code);
        pass_map = map;
        start_sweep();
        n = 0; done_at = -1; bad = 0;
        while (n < 700 && done_at < 0) begin
            if (cal_done === 1'b1) begin
                done_at = n;
            end else begin
                if (n < C_DONE_N && (otrip_cal !== 3'(n / C_CODE_CYC) || cal_active !== 1'b1))
                    bad++;
                if (glitch_c0 && n == 66) glitch = 1'b1;
                if (n == 67) glitch = 1'b0;
                if (start_noise && n == 100) start = 1'b1;
                if (n == 101) start = 1'b0;
                tick();
                n++;
            end
        end
        checks++;
        if (done_at !== C_DONE_N) begin
            errors++;
            $display("FAIL %s done_latency: cal_done at %0d, required %0d", name, done_at, C_DONE_N);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s sweep_trace: %0d bad cycles, required 0", name, bad);
        end
        tick();
        checks++;
        if (cal_done !== 1'b0 || cal_active !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b active=%b, required 0 0", name, cal_done, cal_active);
        end
        checks++;
        if (hit_map !== map) begin
            errors++;
            $display("FAIL %s hit_map: got %h, required %h", name, hit_map, map);
        end
        checks++;
        if (cal_valid !== exp_ok || cal_fail !== !exp_ok) begin
            errors++;
            $display("FAIL %s verdict: valid=%b fail=%b, required %b %b", name, cal_valid, cal_fail,
                     exp_ok, !exp_ok);
        end
        checks++;
        if (cal_code !== exp_code || otrip_cal !== exp_code) begin
            errors++;
            $display("FAIL %s result_code: cal_code=%0d otrip=%0d, required %0d", name, cal_code,
                     otrip_cal, exp_code);
        end
        m_code = exp_code; m_valid = exp_ok; m_fail = !exp_ok; m_hit = map;
    endtask

    task automatic test_abort();
        int bad;
        pass_map = 8'h3F;
        start_sweep();
        for (int n = 0; n < 226; n++) begin
            if (n == 50) start = 1'b1;
            if (n == 51) start = 1'b0;
            tick();
        end
        checks++;
        if (otrip_cal !== 3'd3 || cal_active !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: otrip=%0d active=%b, required 3 1", otrip_cal, cal_active);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (cal_active !== 1'b0 || otrip_cal !== m_code) begin
            errors++;
            $display("FAIL abort_idle: active=%b otrip=%0d, required 0 %0d", cal_active, otrip_cal, m_code);
        end
        checks++;
        if (cal_valid !== 1'b0 || cal_fail !== 1'b0 || cal_code !== m_code) begin
            errors++;
            $display("FAIL abort_results: valid=%b fail=%b code=%0d, required 0 0 %0d", cal_valid,
                     cal_fail, cal_code, m_code);
        end
        checks++;
        if (hit_map !== (8'h3F & 8'h07)) begin
            errors++;
            $display("FAIL abort_partial_map: got %h, required 07", hit_map);
        end
        bad = 0;
        for (int i = 0; i < 700; i++) begin
            if (cal_done !== 1'b0 || cal_active !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d bad cycles, required 0", bad);
        end
        m_valid = 1'b0; m_fail = 1'b0; m_hit = 8'h07;
    endtask

    task automatic test_start_abort_same();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (5) tick();
        checks++;
        if (cal_active !== 1'b0 || hit_map !== m_hit || otrip_cal !== m_code) begin
            errors++;
            $display("FAIL start_abort_same: active=%b hit=%h otrip=%0d, required 0 %h %0d",
                     cal_active, hit_map, otrip_cal, m_hit, m_code);
        end
    endtask

    task automatic test_reset_mid();
        pass_map = 8'h3F;
        start_sweep();
        for (int n = 0; n < 2 * C_CODE_CYC + 64 + 3; n++) tick();
        checks++;
        if (otrip_cal !== 3'd2 || cal_active !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: otrip=%0d active=%b, required 2 1", otrip_cal, cal_active);
        end
        resetb = 1'b0;
        #1;
        checks++;
        if (otrip_cal !== 3'd4 || cal_code !== 3'd4 || hit_map !== 8'h00 || cal_active !== 1'b0 ||
            cal_valid !== 1'b0 || cal_fail !== 1'b0 || cal_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: otrip=%0d code=%0d hit=%h act=%b val=%b fail=%b done=%b, required 4 4 00 0 0 0 0",
                     otrip_cal, cal_code, hit_map, cal_active, cal_valid, cal_fail, cal_done);
        end
        tick();
        resetb = 1'b1;
        tick();
        m_code = 3'd4; m_valid = 1'b0; m_fail = 1'b0; m_hit = 8'h00;
    endtask

    initial begin
        logic [8:0] therm;
        checks = 0;
        errors = 0;
        resetb = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;

        test_reset();
        test_sweep(8'h3F, 1'b0, 1'b1, "pass_0to5");
        test_sweep(8'h00, 1'b1, 1'b0, "all_fail_glitch");
        test_sweep(8'h0B, 1'b0, 1'b0, "non_monotonic");
        test_sweep(8'hFF, 1'b0, 1'b0, "all_pass");
        test_sweep(8'h01, 1'b0, 1'b0, "only_code0");
        test_sweep(8'h80, 1'b0, 1'b0, "only_code7");
        test_sweep(8'h3F, 1'b0, 1'b0, "pre_abort");
        test_abort();
        test_start_abort_same();
        for (int r = 0; r < 5; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                therm = (9'd1 << $urandom_range(0, 8)) - 9'd1;
                test_sweep(therm[7:0], 1'b0, 1'b1, "random_therm");
            end else begin
                test_sweep(8'($urandom), 1'b0, 1'b0, "random_map");
            end
        end
        test_sweep(8'h1F, 1'b0, 1'b0, "pre_reset");
        test_reset_mid();
        test_sweep(8'h07, 1'b0, 1'b0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
